asi_w: RTL and testbench
========================

# asi_w

AXI slave write interface: the responder end of an AXI write port, single clock domain. Accepts AW bursts into a small queue and executes them one at a time. Converts each W beat into a user-side byte-addressed write strobe with AXI FIXED/INCR/WRAP address sequencing. Queues one B response per completed burst. Sits between an AXI interconnect (or an AXI master interface) and on-chip memory or register logic.

## Interface
- AXI_DW, 128, data bus width
- AXI_AW, 32, address width (>= 32)
- AXI_IW, 8, ID width
- AXI_LW, 8, AWLEN width
- AXI_SW, 3, AWSIZE width
- ASI_AD, 4, AW queue depth (power of 2)
- ASI_BD, 4, B queue depth (power of 2)
- AXI_WSTRBW, AXI_DW/8, WSTRB width (derived)

Ports:
- ACLK  in  1  clock; one clock, all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  AXI_IW/AXI_AW/AXI_LW/AXI_SW/2  write address
- AWVALID  in  1;  AWREADY  out  1
- WDATA/WSTRB/WLAST  in  AXI_DW/AXI_WSTRBW/1  write data
- WVALID  in  1;  WREADY  out  1
- BID/BRESP  out  AXI_IW/2  write response
- BVALID  out  1;  BREADY  in  1
- usr_we  out  1  write strobe, one per accepted beat
- usr_waddr  out  AXI_AW  byte address of current beat
- usr_wdata/usr_wstrb  out  AXI_DW/AXI_WSTRBW  beat data/strobes, WDATA/WSTRB passed through
- usr_wlast  out  1  final beat of burst (per AWLEN count)
- usr_wready  in  1  user can accept a beat this cycle
- usr_werr  in  1  user error for current beat, sampled when usr_we=1

## Operation
- AW queue: synchronous FIFO, depth ASI_AD, first-word-fall-through. AWREADY = !aq_full. Push on AWVALID&AWREADY.
- B queue: synchronous FIFO, depth ASI_BD, entries {id, resp}. BVALID = !bq_empty. BID/BRESP = head. Pop on BVALID&BREADY.
- FSM states IDLE, DATA.
  - IDLE: if !aq_empty && !bq_full, pop AW and go to DATA. The pop loads id, addr, len, size, burst; clears beat_cc and err.
  - DATA: WREADY = usr_wready. Beat = WVALID&WREADY.
  - On each beat: beat_cc++, err |= usr_werr | (WLAST != (beat_cc==len)).
  - On the beat with beat_cc==len: push {id, err_final ? 2'b10 : 2'b00} to B queue, return to IDLE.
- Burst length is governed solely by AWLEN. A WLAST mismatch only flags SLVERR.
- usr_we = DATA && WVALID && usr_wready && !bad. usr_wdata/usr_wstrb = WDATA/WSTRB combinationally. usr_wlast = (beat_cc==len). usr_waddr = current addr register.
- bad (latched at AW pop) when AWSIZE > log2(AXI_WSTRBW), or AWBURST==2'b11, or WRAP with len not in {1,3,7,15}.
  - Beats are still consumed (WREADY = 1 regardless of usr_wready).
  - usr_we is held 0 for the burst.
  - Response is SLVERR.
- Address update after each beat, with bytes = 1<<size:
  - FIXED: unchanged.
  - INCR: (addr & ~(bytes-1)) + bytes. The first beat uses the raw unaligned AWADDR; later beats are aligned.
  - WRAP: wl = (len+1)*bytes; next = (addr & ~(wl-1)) | ((addr+bytes) & (wl-1)).
  - Arithmetic is modulo 2^AXI_AW. No 4KB check.
- Reset values: AWREADY 0, WREADY 0, BVALID 0, BID 0, BRESP 0, usr_we 0, usr_waddr 0, usr_wlast 0, FSM IDLE. Both queues are emptied.
  - AWREADY rises the cycle after ARESET deasserts.
  - Reset mid-burst discards the burst and all queued AW/B entries. No B is issued.

## Timing
- AW handshake at cycle N → entry visible at N+1 → IDLE pops at N+1 → DATA, WREADY possible from N+2.
- One beat per cycle max in DATA, no bubbles while WVALID&usr_wready.
- Last beat at cycle M: B pushed at edge M, BVALID at M+1. FSM is in IDLE at M+1, next burst's DATA at M+2 (one dead cycle between bursts).
- Queue boundaries:
  - Simultaneous push/pop on a full or empty queue is legal. Occupancy is unchanged; data ordering is preserved.
  - bq_full blocks the IDLE pop, so the B queue never overflows.
  - BREADY stuck low stalls new bursts after ASI_BD responses.
- WREADY is 0 in IDLE. W beats arriving before their AW wait (no W buffering).

## Test plan
- INCR, AWADDR 0x1000, AWLEN 3, AWSIZE 4, W back-to-back → usr_waddr 0x1000/0x1010/0x1020/0x1030. usr_wlast on 4th beat. BRESP 0, BID echoes. BVALID 1 cycle after last beat.
- WRAP, AWADDR 0x1038, AWLEN 3, AWSIZE 3 → addresses 0x1038, 0x1020, 0x1028, 0x1030. FIXED, AWADDR 0x40, AWLEN 2 → 0x40 ×3.
- Errors:
  - AWLEN 1 with WLAST on beat 0 → 2 beats consumed, BRESP 2'b10.
  - AWSIZE 5 (AXI_DW=128) → usr_we never 1, BRESP 2'b10.
  - usr_werr on beat 2 of 4 → BRESP 2'b10.
- Backpressure:
  - Hold BREADY 0, issue 6 single-beat bursts (ASI_AD=ASI_BD=4) → 4 B entries queued, 5th burst not started, AWREADY 0 once AW queue fills.
  - Release BREADY → all 6 B in order.
  - Toggle usr_wready randomly → beats/addresses unchanged, no dropped beats.
- Assert ARESET mid-burst (beat 2 of 8) → next cycle all outputs at reset values. No B for that ID. A fresh burst after reset completes normally.

Source files
------------

// File: rtl/asi_w_if.sv
// ---------------------------------------------------------------------------
// asi_w_if : AXI write-channel bundle (AW, W and B) between a write master
// and the asi_w responder.
//   AW : AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID / AWREADY
//   W  : WDATA, WSTRB, WLAST, WVALID / WREADY
//   B  : BID, BRESP, BVALID / BREADY
// modport master drives AW/W and BREADY; modport slave drives the rest.
// ---------------------------------------------------------------------------
interface asi_w_if #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3
);
    localparam int AXI_WSTRBW = AXI_DW / 8;

    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [AXI_SW-1:0]     AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_IW-1:0]     BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/asi_w.sv
// ---------------------------------------------------------------------------
// asi_w : AXI slave write interface.
// Queues AW bursts (FWFT FIFO, depth ASI_AD), executes them one at a time,
// turns every W beat into a user-side byte-addressed write with FIXED/INCR/
// WRAP address sequencing, and queues one B response per burst (FIFO, depth
// ASI_BD).
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   s_axi (slave)      AW / W / B channels
//   usr_we             one strobe per accepted, legal beat
//   usr_waddr          byte address of the current beat
//   usr_wdata/wstrb    WDATA/WSTRB passed through
//   usr_wlast          current beat is the final one per AWLEN
//   usr_wready         user can take a beat this cycle
//   usr_werr           user error for the current beat (sampled with usr_we)
// ---------------------------------------------------------------------------
module asi_w #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int ASI_AD     = 4,
    parameter int ASI_BD     = 4,
    parameter int AXI_WSTRBW = AXI_DW / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    asi_w_if.slave                s_axi,
    output logic                  usr_we,
    output logic [AXI_AW-1:0]     usr_waddr,
    output logic [AXI_DW-1:0]     usr_wdata,
    output logic [AXI_WSTRBW-1:0] usr_wstrb,
    output logic                  usr_wlast,
    input  logic                  usr_wready,
    input  logic                  usr_werr
);
    localparam int AQ_W  = AXI_IW + AXI_AW + AXI_LW + AXI_SW + 2;
    localparam int BQ_W  = AXI_IW + 2;
    localparam int AQ_PW = (ASI_AD > 1) ? $clog2(ASI_AD) : 1;
    localparam int BQ_PW = (ASI_BD > 1) ? $clog2(ASI_BD) : 1;
    localparam logic [AXI_SW-1:0] SZ_MAX = AXI_SW'($clog2(AXI_WSTRBW));

    typedef enum logic [0:0] {ST_IDLE, ST_DATA} state_t;

    // ---------------- AW queue ----------------
    logic [AQ_W-1:0]   r_aq_mem [ASI_AD];
    logic [AQ_PW-1:0]  r_aq_wp, r_aq_rp;
    logic [AQ_PW:0]    r_aq_cnt;
    logic              w_aq_full, w_aq_empty, w_aq_push, w_aq_pop;
    logic [AXI_IW-1:0] w_h_id;
    logic [AXI_AW-1:0] w_h_addr;
    logic [AXI_LW-1:0] w_h_len;
    logic [AXI_SW-1:0] w_h_size;
    logic [1:0]        w_h_burst;
    logic              w_h_bad;

    // ---------------- B queue ----------------
    logic [BQ_W-1:0]   r_bq_mem [ASI_BD];
    logic [BQ_PW-1:0]  r_bq_wp, r_bq_rp;
    logic [BQ_PW:0]    r_bq_cnt;
    logic              w_bq_full, w_bq_empty, w_bq_push, w_bq_pop;
    logic [BQ_W-1:0]   w_bq_din;

    // ---------------- burst context ----------------
    state_t            r_state, w_state_nxt;
    logic              r_run;
    logic [AXI_IW-1:0] r_id;
    logic [AXI_AW-1:0] r_addr;
    logic [AXI_LW-1:0] r_len;
    logic [AXI_SW-1:0] r_size;
    logic [1:0]        r_burst;
    logic [AXI_LW-1:0] r_beat_cc;
    logic              r_err, r_bad;

    logic              w_in_data, w_last, w_wready, w_beat, w_err_nxt;
    logic [AXI_AW-1:0] w_bytes, w_wl, w_addr_nxt;

    assign w_aq_full  = (r_aq_cnt == (AQ_PW+1)'(ASI_AD));
    assign w_aq_empty = (r_aq_cnt == (AQ_PW+1)'(0));
    assign w_aq_push  = s_axi.AWVALID & s_axi.AWREADY;
    assign {w_h_id, w_h_addr, w_h_len, w_h_size, w_h_burst} = r_aq_mem[r_aq_rp];

    // An illegal burst is still drained but never reaches the user side.
    assign w_h_bad = (w_h_size > SZ_MAX) || (w_h_burst == 2'b11) ||
                     ((w_h_burst == 2'b10) &&
                      !((w_h_len == AXI_LW'(1)) || (w_h_len == AXI_LW'(3)) ||
                        (w_h_len == AXI_LW'(7)) || (w_h_len == AXI_LW'(15))));

    assign w_bq_full  = (r_bq_cnt == (BQ_PW+1)'(ASI_BD));
    assign w_bq_empty = (r_bq_cnt == (BQ_PW+1)'(0));
    assign w_bq_pop   = s_axi.BVALID & s_axi.BREADY;

    assign w_in_data = (r_state == ST_DATA);
    assign w_last    = (r_beat_cc == r_len);
    // A WLAST that disagrees with the AWLEN count only marks the burst as failed.
    assign w_err_nxt = r_err | (usr_we & usr_werr) | (s_axi.WLAST != w_last);
    assign w_bq_din  = {r_id, (w_err_nxt | r_bad) ? 2'b10 : 2'b00};

    // AW queue storage
    always_ff @(posedge ACLK) begin
        if (w_aq_push) begin
            r_aq_mem[r_aq_wp] <= {s_axi.AWID, s_axi.AWADDR, s_axi.AWLEN,
                                  s_axi.AWSIZE, s_axi.AWBURST};
        end
    end

    // AW queue pointers and occupancy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aq_wp  <= AQ_PW'(0);
            r_aq_rp  <= AQ_PW'(0);
            r_aq_cnt <= (AQ_PW+1)'(0);
        end else begin
            if (w_aq_push) r_aq_wp <= r_aq_wp + AQ_PW'(1);
            if (w_aq_pop)  r_aq_rp <= r_aq_rp + AQ_PW'(1);
            case ({w_aq_push, w_aq_pop})
                2'b10:   r_aq_cnt <= r_aq_cnt + (AQ_PW+1)'(1);
                2'b01:   r_aq_cnt <= r_aq_cnt - (AQ_PW+1)'(1);
                default: r_aq_cnt <= r_aq_cnt;
            endcase
        end
    end

    // B queue storage
    always_ff @(posedge ACLK) begin
        if (w_bq_push) begin
            r_bq_mem[r_bq_wp] <= w_bq_din;
        end
    end

    // B queue pointers and occupancy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bq_wp  <= BQ_PW'(0);
            r_bq_rp  <= BQ_PW'(0);
            r_bq_cnt <= (BQ_PW+1)'(0);
        end else begin
            if (w_bq_push) r_bq_wp <= r_bq_wp + BQ_PW'(1);
            if (w_bq_pop)  r_bq_rp <= r_bq_rp + BQ_PW'(1);
            case ({w_bq_push, w_bq_pop})
                2'b10:   r_bq_cnt <= r_bq_cnt + (BQ_PW+1)'(1);
                2'b01:   r_bq_cnt <= r_bq_cnt - (BQ_PW+1)'(1);
                default: r_bq_cnt <= r_bq_cnt;
            endcase
        end
    end

    // Holds AWREADY low during reset and for the reset-release cycle
    always_ff @(posedge ACLK) begin
        if (ARESET) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state, queue pop/push and W acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_aq_pop    = 1'b0;
        w_bq_push   = 1'b0;
        w_wready    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only start a burst if its response is guaranteed a B slot.
                if (!w_aq_empty && !w_bq_full) begin
                    w_aq_pop    = 1'b1;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                w_wready = r_bad | usr_wready;
                w_beat   = s_axi.WVALID & w_wready;
                if (w_beat && w_last) begin
                    w_bq_push   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Wrap window size: (len+1)*bytes for the legal wrap lengths
    always_comb begin
        w_bytes = AXI_AW'(1) << r_size;
        case (r_len)
            AXI_LW'(1):  w_wl = w_bytes << 1;
            AXI_LW'(3):  w_wl = w_bytes << 2;
            AXI_LW'(7):  w_wl = w_bytes << 3;
            AXI_LW'(15): w_wl = w_bytes << 4;
            default:     w_wl = w_bytes;
        endcase
    end

    // Next beat address; INCR aligns after the first (possibly unaligned) beat
    always_comb begin
        case (r_burst)
            2'b00:   w_addr_nxt = r_addr;
            2'b01:   w_addr_nxt = (r_addr & ~(w_bytes - AXI_AW'(1))) + w_bytes;
            2'b10:   w_addr_nxt = (r_addr & ~(w_wl - AXI_AW'(1))) |
                                  ((r_addr + w_bytes) & (w_wl - AXI_AW'(1)));
            default: w_addr_nxt = r_addr;
        endcase
    end

    // Burst context: loaded on AW pop, advanced on each beat
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_id      <= AXI_IW'(0);
            r_addr    <= AXI_AW'(0);
            r_len     <= AXI_LW'(0);
            r_size    <= AXI_SW'(0);
            r_burst   <= 2'b00;
            r_beat_cc <= AXI_LW'(0);
            r_err     <= 1'b0;
            r_bad     <= 1'b0;
        end else if (w_aq_pop) begin
            r_id      <= w_h_id;
            r_addr    <= w_h_addr;
            r_len     <= w_h_len;
            r_size    <= w_h_size;
            r_burst   <= w_h_burst;
            r_beat_cc <= AXI_LW'(0);
            r_err     <= 1'b0;
            r_bad     <= w_h_bad;
        end else if (w_beat) begin
            r_addr    <= w_addr_nxt;
            r_beat_cc <= r_beat_cc + AXI_LW'(1);
            r_err     <= w_err_nxt;
        end else begin
            r_addr    <= r_addr;
        end
    end

    assign s_axi.AWREADY = r_run & ~w_aq_full;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = ~w_bq_empty;
    // Head is gated so an empty queue presents zeros rather than stale data.
    assign {s_axi.BID, s_axi.BRESP} = w_bq_empty ? BQ_W'(0) : r_bq_mem[r_bq_rp];

    assign usr_we    = w_in_data & s_axi.WVALID & usr_wready & ~r_bad;
    assign usr_waddr = r_addr;
    assign usr_wdata = s_axi.WDATA;
    assign usr_wstrb = s_axi.WSTRB;
    assign usr_wlast = w_in_data & w_last;
endmodule

// File: tb/tb_asi_w.sv
// ---------------------------------------------------------------------------
// tb_asi_w : self-checking bench for asi_w. Directed and random bursts are
// checked against a reference model that derives each beat address and each
// response directly from burst parameters.
// ---------------------------------------------------------------------------
module tb_asi_w;
    localparam int DW = 128, AW = 32, IW = 8, LW = 8, SW = 3, SB = DW / 8;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    asi_w_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW)) axi ();

    logic          usr_we, usr_wlast, usr_wready, usr_werr;
    logic [AW-1:0] usr_waddr;
    logic [DW-1:0] usr_wdata;
    logic [SB-1:0] usr_wstrb;

    asi_w #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
            .ASI_AD(4), .ASI_BD(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(axi),
        .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata),
        .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast),
        .usr_wready(usr_wready), .usr_werr(usr_werr)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SB-1:0] strb;
        logic          last;
    } beat_t;

    beat_t         exp_beats[$], got_beats[$];
    logic [IW+1:0] exp_b[$], got_b[$];
    int  total = 0;
    int  bad   = 0;
    bit  rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: beat i address from burst parameters
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int len,
                                                 input int size, input int burst, input int i);
        logic [AW-1:0] bytes, wl, base, off;
        bytes = AW'(1) << size;
        case (burst)
            0: return a;
            1: return (i == 0) ? a : ((a / bytes) * bytes) + AW'(i) * bytes;
            default: begin
                wl   = AW'(len + 1) * bytes;
                base = (a / wl) * wl;
                off  = (a - base + AW'(i) * bytes) % wl;
                return base + off;
            end
        endcase
    endfunction

    function automatic bit model_bad(input int len, input int size, input int burst);
        return (size > 4) || (burst == 3) ||
               ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // User-side readiness: constant 1 or random per cycle
    initial begin
        usr_wready = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            usr_wready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor user writes and B handshakes
    always @(negedge ACLK) begin
        if (!ARESET && usr_we)
            got_beats.push_back('{usr_waddr, usr_wdata, usr_wstrb, usr_wlast});
        if (!ARESET && axi.BVALID && axi.BREADY)
            got_b.push_back({axi.BID, axi.BRESP});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] a,
                           input int len, input int size, input int burst);
        int n;
        n = 0;
        axi.AWID = id; axi.AWADDR = a; axi.AWLEN = LW'(len);
        axi.AWSIZE = SW'(size); axi.AWBURST = 2'(burst); axi.AWVALID = 1'b1;
        @(negedge ACLK);
        while (axi.AWREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        chk("aw_handshake", DW'(n < 200), DW'(1));
        @(posedge ACLK); #1;
        axi.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SB-1:0] s,
                          input bit lastf, input bit werr, input bit is_final);
        int n;
        n = 0;
        axi.WDATA = d; axi.WSTRB = s; axi.WLAST = lastf; usr_werr = werr;
        axi.WVALID = 1'b1;
        @(negedge ACLK);
        while (axi.WREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        chk("w_handshake", DW'(n < 200), DW'(1));
        @(posedge ACLK); #1;
        axi.WVALID = 1'b0; axi.WLAST = 1'b0; usr_werr = 1'b0;
        if (is_final) chk("bvalid_after_last", DW'(axi.BVALID), DW'(1));
    endtask

    task automatic send_data(input logic [IW-1:0] id, input logic [AW-1:0] a, input int len,
                             input int size, input int burst, input int wlast_at, input int werr_at);
        bit isbad, err, lastf;
        logic [DW-1:0] d;
        logic [SB-1:0] s;
        isbad = model_bad(len, size, burst);
        err   = isbad;
        for (int i = 0; i <= len; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            s = SB'($urandom);
            lastf = (i == wlast_at);
            if (lastf != (i == len)) err = 1'b1;
            if (i == werr_at) err = 1'b1;
            if (!isbad) exp_beats.push_back('{model_addr(a, len, size, burst, i), d, s, i == len});
            send_w(d, s, lastf, i == werr_at, i == len);
        end
        exp_b.push_back({id, err ? 2'b10 : 2'b00});
    endtask

    task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input int len,
                            input int size, input int burst, input int wlast_at, input int werr_at);
        send_aw(id, a, len, size, burst);
        send_data(id, a, len, size, burst, wlast_at, werr_at);
    endtask

    task automatic compare_all(input string tag);
        repeat (4) @(posedge ACLK);
        #1;
        chk({tag, "_nbeats"}, DW'(got_beats.size()), DW'(exp_beats.size()));
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            chk({tag, "_addr"}, DW'(got_beats[i].addr), DW'(exp_beats[i].addr));
            chk({tag, "_data"}, got_beats[i].data, exp_beats[i].data);
            chk({tag, "_strb"}, DW'(got_beats[i].strb), DW'(exp_beats[i].strb));
            chk({tag, "_last"}, DW'(got_beats[i].last), DW'(exp_beats[i].last));
        end
        chk({tag, "_nresp"}, DW'(got_b.size()), DW'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            chk({tag, "_bid_bresp"}, DW'(got_b[i]), DW'(exp_b[i]));
        exp_beats.delete(); got_beats.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, DW'(axi.AWREADY), DW'(0));
        chk({tag, "_wready"},  DW'(axi.WREADY),  DW'(0));
        chk({tag, "_bvalid"},  DW'(axi.BVALID),  DW'(0));
        chk({tag, "_bid"},     DW'(axi.BID),     DW'(0));
        chk({tag, "_bresp"},   DW'(axi.BRESP),   DW'(0));
        chk({tag, "_usr_we"},  DW'(usr_we),      DW'(0));
        chk({tag, "_waddr"},   DW'(usr_waddr),   DW'(0));
        chk({tag, "_wlast"},   DW'(usr_wlast),   DW'(0));
    endtask

    initial begin
        int len, size, burst, wl_at, we_at;
        logic [AW-1:0] a;
        axi.AWVALID = 1'b0; axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0;
        axi.AWSIZE = '0; axi.AWBURST = '0;
        axi.WVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0;
        axi.BREADY = 1'b1; usr_werr = 1'b0; ARESET = 1'b1;

        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outputs("reset");
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_release_cycle", DW'(axi.AWREADY), DW'(0));
        @(posedge ACLK); #1;
        chk("awready_after_release", DW'(axi.AWREADY), DW'(1));

        // Directed bursts
        do_burst(8'h11, 32'h1000, 3, 4, 1, 3, -1);  compare_all("incr");
        do_burst(8'h22, 32'h1038, 3, 3, 2, 3, -1);  compare_all("wrap");
        do_burst(8'h33, 32'h0040, 2, 4, 0, 2, -1);  compare_all("fixed");
        do_burst(8'h44, 32'h2000, 1, 4, 1, 0, -1);  compare_all("wlast_early");
        do_burst(8'h55, 32'h3000, 3, 5, 1, 3, -1);  compare_all("size5");
        do_burst(8'h66, 32'h4000, 3, 4, 1, 3, 2);   compare_all("werr");
        do_burst(8'h67, 32'h4100, 1, 2, 3, 1, -1);  compare_all("burst_rsvd");
        do_burst(8'h68, 32'h4200, 2, 2, 2, 2, -1);  compare_all("wrap_len2");

        // B backpressure: four bursts fill the B queue, the fifth must stall
        axi.BREADY = 1'b0;
        for (int k = 0; k < 5; k++) send_aw(IW'(8'hA0 + k), AW'(32'h5000 + k * 16), 0, 4, 1);
        chk("awready_aq_full", DW'(axi.AWREADY), DW'(0));
        for (int k = 0; k < 4; k++) send_data(IW'(8'hA0 + k), AW'(32'h5000 + k * 16), 0, 4, 1, 0, -1);
        send_aw(8'hA5, 32'h5050, 0, 4, 1);
        axi.WVALID = 1'b1; axi.WLAST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("stall_wready", DW'(axi.WREADY), DW'(0));
            chk("stall_bvalid", DW'(axi.BVALID), DW'(1));
            chk("stall_usr_we", DW'(usr_we), DW'(0));
        end
        @(posedge ACLK); #1;
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        chk("stall_no_b", DW'(got_b.size()), DW'(0));
        axi.BREADY = 1'b1;
        send_data(8'hA4, 32'h5040, 0, 4, 1, 0, -1);
        send_data(8'hA5, 32'h5050, 0, 4, 1, 0, -1);
        compare_all("backpressure");

        // Random bursts with random usr_wready
        rnd_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            size  = $urandom_range(0, 5);
            burst = $urandom_range(0, 3);
            if (burst == 2) len = (1 << $urandom_range(1, 4)) - 1;
            else            len = $urandom_range(0, 15);
            a     = $urandom;
            wl_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : len;
            we_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
            do_burst(IW'($urandom), a, len, size, burst, wl_at, we_at);
        end
        rnd_ready = 1'b0;
        compare_all("random");

        // Reset in the middle of an 8-beat burst
        send_aw(8'h77, 32'h6000, 7, 4, 1);
        for (int i = 0; i < 2; i++) begin
            exp_beats.push_back('{model_addr(32'h6000, 7, 4, 1, i), DW'(i + 5), SB'(16'hFFFF), 1'b0});
            send_w(DW'(i + 5), SB'(16'hFFFF), 1'b0, 1'b0, 1'b0);
        end
        axi.WVALID = 1'b1; axi.WDATA = DW'(7); ARESET = 1'b1;
        @(posedge ACLK); #1;
        chk_reset_outputs("midburst_reset");
        ARESET = 1'b0; axi.WVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("awready_after_midreset", DW'(axi.AWREADY), DW'(1));
        compare_all("midburst_reset");
        do_burst(8'h78, 32'h7000, 2, 4, 1, 2, -1);
        compare_all("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
